mestre_polinomio: RTL and testbench
===================================

// Module: mestre_polinomio
// PURPOSE
//   Initiator for the polynomial unit `projeto` (inicio/pronto/LED handshake).
//   Sweeps X over N consecutive values with fixed A, B, C and issues one job per X.
//   Captures each Resultado and streams it out with an index.
//   Sits between the control logic and `projeto`, replacing bench-driven stimulus.
// PARAMETERS
//   LARGURA   16  operand/result width (X, A, B, C, Resultado)
//   LARG_CONT 8   width of job count N and result index
//   TIMEOUT   64  max cycles waiting for LED rise or fall before abort
// PORTS
//   ck           in   1          clock, rising edge
//   rst          in   1          reset, asynchronous, active-high
//   cmd_inicio   in   1          start sweep (sampled only in OCIOSO)
//   x0           in   LARGURA    first X value
//   n_jobs       in   LARG_CONT  number of jobs
//   a_in,b_in,c_in in LARGURA    coefficients, latched at cmd_inicio
//   inicio       out  1          to projeto: one-cycle start pulse
//   pronto       out  1          to projeto: one-cycle result acknowledge
//   X,A,B,C      out  LARGURA    to projeto: operands
//   Resultado    in   LARGURA    from projeto: result
//   LED          in   1          from projeto: result valid, held until pronto
//   res_dado     out  LARGURA    captured result
//   res_indice   out  LARG_CONT  job index of res_dado (0..N-1)
//   res_valido   out  1          one-cycle strobe, res_dado/res_indice valid
//   ocupado      out  1          high from accepted cmd_inicio until fim
//   fim          out  1          one-cycle pulse, sweep finished or aborted
//   erro_timeout out  1          sticky abort flag, cleared by next accepted cmd_inicio
// BEHAVIOUR
//   Reset: state OCIOSO; all outputs 0 (inicio, pronto, X/A/B/C, res_*, ocupado, fim, erro_timeout).
//   All outputs registered.
//   FSM OCIOSO -> DISPARA -> ESPERA -> CAPTURA -> LIBERA -> (DISPARA | FIM) -> OCIOSO.
//   OCIOSO:  cmd_inicio=1 latches x0, a_in, b_in, c_in, n_jobs; clears idx and erro_timeout.
//            ocupado=1 next cycle. If n_jobs=0: go to FIM (fim pulse, no job).
//   DISPARA: inicio=1 for exactly one cycle; X/A/B/C stable from here through LIBERA.
//   ESPERA:  wait LED=1; timer counts. LED=1 -> CAPTURA.
//            Timer reaches TIMEOUT-1 with LED=0 -> erro_timeout=1, go to FIM.
//   CAPTURA: res_dado<=Resultado, res_indice<=idx, res_valido=1, pronto=1, all one cycle.
//   LIBERA:  wait LED=0 (same timeout rule, same abort).
//            Then idx==N-1 -> FIM; else X<=X+1 (mod 2^LARGURA, wraps 0xFFFF->0), idx++, -> DISPARA.
//   FIM:     fim=1 one cycle, ocupado<=0, -> OCIOSO.
//   Timer resets on every state entry; no arithmetic on Resultado (pass-through).
//   cmd_inicio outside OCIOSO ignored. LED seen high outside ESPERA/LIBERA is ignored.
//   rst mid-sweep: immediate return to reset values; no pronto issued; projeto is reset by the same rst.
//   Min job period 4 cycles (DISPARA, ESPERA>=1, CAPTURA, LIBERA>=1).
// STRUCTURE
//   Shared package: state encoding constants (OCIOSO..FIM, 3 bits) and default TIMEOUT,
//   shared with projeto's handshake.
//   One sub-module natural: temporizador_handshake (load/clear, count, expired flag).
//   Rest is a single FSM plus operand/index registers.
// TESTING (behavioural projeto model: Resultado = A*X*X + B*X + C mod 2^16, LED after 3 cycles)
//   1. A=38,B=333,C=4902,x0=23,N=1 -> one res_valido: res_dado=32663 (0x7F97), idx 0;
//      then fim; exactly one inicio and one pronto.
//   2. Same coefficients, N=2 -> res_dado 32663 (idx 0) then 34782 (0x87DE, idx 1);
//      X=24 on second inicio; one fim.
//   3. x0=0xFFFF, N=2 -> second job issued with X=0x0000; two results, fim.
//   4. n_jobs=0 -> fim pulse 2 cycles after cmd_inicio; no inicio, no res_valido.
//   5. Model never raises LED -> erro_timeout=1 and fim after TIMEOUT cycles in ESPERA;
//      next cmd_inicio clears erro_timeout.
//   6. rst asserted in ESPERA of job 1 of N=4 -> all outputs 0 asynchronously;
//      cmd_inicio during sweep ignored.

Source files
------------

// File: rtl/mestre_polinomio_pkg.sv
// Shared definitions for the polynomial-unit initiator and its handshake.
// State encoding is 3 bits and matches the handshake used by projeto.
package mestre_polinomio_pkg;

    localparam int TIMEOUT_PADRAO = 64;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        DISPARA = 3'd1,
        ESPERA  = 3'd2,
        CAPTURA = 3'd3,
        LIBERA  = 3'd4,
        FIM     = 3'd5
    } estado_t;

endpackage

// File: rtl/mestre_polinomio_temporizador.sv
// Handshake watchdog: cleared on state entry, counts while waiting on LED.
// Saturates at TIMEOUT-1 and flags expiry.
module mestre_polinomio_temporizador
    import mestre_polinomio_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_PADRAO
) (
    input  logic ck,
    input  logic rst,
    input  logic limpa_i,
    input  logic conta_i,
    output logic expirou_o
);

    localparam int LT = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [LT-1:0] cont_q, cont_d;

    assign expirou_o = (cont_q == LT'(TIMEOUT - 1));

    always_comb begin
        cont_d = cont_q;
        if (limpa_i) begin
            cont_d = '0;
        end else if (conta_i && !expirou_o) begin
            cont_d = cont_q + LT'(1);
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

endmodule

// File: rtl/mestre_polinomio.sv
// Initiator for projeto: sweeps X over N values with fixed A/B/C,
// issues one job per X and streams each result out with its index.
module mestre_polinomio
    import mestre_polinomio_pkg::*;
#(
    parameter int LARGURA   = 16,
    parameter int LARG_CONT = 8,
    parameter int TIMEOUT   = TIMEOUT_PADRAO
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic                 cmd_inicio,
    input  logic [LARGURA-1:0]   x0,
    input  logic [LARG_CONT-1:0] n_jobs,
    input  logic [LARGURA-1:0]   a_in,
    input  logic [LARGURA-1:0]   b_in,
    input  logic [LARGURA-1:0]   c_in,
    output logic                 inicio,
    output logic                 pronto,
    output logic [LARGURA-1:0]   X,
    output logic [LARGURA-1:0]   A,
    output logic [LARGURA-1:0]   B,
    output logic [LARGURA-1:0]   C,
    input  logic [LARGURA-1:0]   Resultado,
    input  logic                 LED,
    output logic [LARGURA-1:0]   res_dado,
    output logic [LARG_CONT-1:0] res_indice,
    output logic                 res_valido,
    output logic                 ocupado,
    output logic                 fim,
    output logic                 erro_timeout
);

    estado_t estado_q, estado_d;

    logic [LARGURA-1:0]   x_q, x_d, a_q, a_d, b_q, b_d, c_q, c_d;
    logic [LARG_CONT-1:0] n_q, n_d, idx_q, idx_d;
    logic [LARGURA-1:0]   res_dado_q, res_dado_d;
    logic [LARG_CONT-1:0] res_indice_q, res_indice_d;
    logic inicio_q, inicio_d, pronto_q, pronto_d;
    logic res_valido_q, res_valido_d;
    logic ocupado_q, ocupado_d, fim_q, fim_d;
    logic erro_q, erro_d;
    logic expirou, ultimo;

    mestre_polinomio_temporizador #(
        .TIMEOUT (TIMEOUT)
    ) u_temp (
        .ck        (ck),
        .rst       (rst),
        .limpa_i   (estado_d != estado_q),
        .conta_i   ((estado_q == ESPERA) || (estado_q == LIBERA)),
        .expirou_o (expirou)
    );

    assign ultimo = (idx_q == n_q - LARG_CONT'(1));

    always_comb begin
        estado_d     = estado_q;
        x_d          = x_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        n_d          = n_q;
        idx_d        = idx_q;
        res_dado_d   = res_dado_q;
        res_indice_d = res_indice_q;
        ocupado_d    = ocupado_q;
        erro_d       = erro_q;
        // Strobes follow the state one cycle later so every output is a flop.
        inicio_d     = (estado_q == DISPARA);
        pronto_d     = (estado_q == CAPTURA);
        res_valido_d = (estado_q == CAPTURA);
        fim_d        = (estado_q == FIM);
        unique case (estado_q)
            OCIOSO: begin
                if (cmd_inicio) begin
                    x_d       = x0;
                    a_d       = a_in;
                    b_d       = b_in;
                    c_d       = c_in;
                    n_d       = n_jobs;
                    idx_d     = '0;
                    erro_d    = 1'b0;
                    ocupado_d = 1'b1;
                    estado_d  = (n_jobs == '0) ? FIM : DISPARA;
                end
            end
            DISPARA: estado_d = ESPERA;
            ESPERA: begin
                if (LED) begin
                    estado_d = CAPTURA;
                end else if (expirou) begin
                    erro_d   = 1'b1;
                    estado_d = FIM;
                end
            end
            CAPTURA: begin
                res_dado_d   = Resultado;
                res_indice_d = idx_q;
                estado_d     = LIBERA;
            end
            LIBERA: begin
                if (!LED) begin
                    if (ultimo) begin
                        estado_d = FIM;
                    end else begin
                        x_d      = x_q + LARGURA'(1);
                        idx_d    = idx_q + LARG_CONT'(1);
                        estado_d = DISPARA;
                    end
                end else if (expirou) begin
                    erro_d   = 1'b1;
                    estado_d = FIM;
                end
            end
            FIM: begin
                ocupado_d = 1'b0;
                estado_d  = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            estado_q     <= OCIOSO;
            x_q          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            n_q          <= '0;
            idx_q        <= '0;
            res_dado_q   <= '0;
            res_indice_q <= '0;
            inicio_q     <= 1'b0;
            pronto_q     <= 1'b0;
            res_valido_q <= 1'b0;
            ocupado_q    <= 1'b0;
            fim_q        <= 1'b0;
            erro_q       <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            x_q          <= x_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            res_dado_q   <= res_dado_d;
            res_indice_q <= res_indice_d;
            inicio_q     <= inicio_d;
            pronto_q     <= pronto_d;
            res_valido_q <= res_valido_d;
            ocupado_q    <= ocupado_d;
            fim_q        <= fim_d;
            erro_q       <= erro_d;
        end
    end

    assign inicio       = inicio_q;
    assign pronto       = pronto_q;
    assign X            = x_q;
    assign A            = a_q;
    assign B            = b_q;
    assign C            = c_q;
    assign res_dado     = res_dado_q;
    assign res_indice   = res_indice_q;
    assign res_valido   = res_valido_q;
    assign ocupado      = ocupado_q;
    assign fim          = fim_q;
    assign erro_timeout = erro_q;

endmodule

// File: tb/tb_mestre_polinomio.sv
// Bench for mestre_polinomio with a behavioural projeto model
// and a reference sweep computed from the polynomial directly.
module tb_mestre_polinomio;

    localparam int W  = 16;
    localparam int WC = 8;
    localparam int TO = 64;

    logic          ck = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_inicio = 1'b0;
    logic [W-1:0]  x0 = '0, a_in = '0, b_in = '0, c_in = '0;
    logic [WC-1:0] n_jobs = '0;
    logic          inicio, pronto, res_valido, ocupado, fim, erro_timeout;
    logic [W-1:0]  X, A, B, C, res_dado;
    logic [WC-1:0] res_indice;
    logic          LED = 1'b0;
    logic [W-1:0]  Resultado = '0;

    mestre_polinomio #(
        .LARGURA   (W),
        .LARG_CONT (WC),
        .TIMEOUT   (TO)
    ) dut (
        .ck           (ck),
        .rst          (rst),
        .cmd_inicio   (cmd_inicio),
        .x0           (x0),
        .n_jobs       (n_jobs),
        .a_in         (a_in),
        .b_in         (b_in),
        .c_in         (c_in),
        .inicio       (inicio),
        .pronto       (pronto),
        .X            (X),
        .A            (A),
        .B            (B),
        .C            (C),
        .Resultado    (Resultado),
        .LED          (LED),
        .res_dado     (res_dado),
        .res_indice   (res_indice),
        .res_valido   (res_valido),
        .ocupado      (ocupado),
        .fim          (fim),
        .erro_timeout (erro_timeout)
    );

    always #5 ck = ~ck;

    int vecs = 0;
    int erros = 0;

    // projeto model settings
    int m_atraso = 3;
    bit m_never = 1'b0;

    // monitor / projeto model state
    int          ciclo = 0, ciclo_ini = 0, ciclo_fim = 0;
    int          n_inicio = 0, n_pronto = 0, n_fim = 0;
    int          cnt = 0;
    logic [W-1:0] op_x = '0, op_a = '0, op_b = '0, op_c = '0;
    logic [W-1:0]  q_dado[$];
    logic [WC-1:0] q_idx[$];
    logic [W-1:0]  q_x[$];
    logic [3*W-1:0] q_abc[$];

    function automatic logic [W-1:0] poli(input logic [W-1:0] a, b, c, x);
        logic [31:0] r;
        r = 32'(a) * 32'(x) * 32'(x) + 32'(b) * 32'(x) + 32'(c);
        return r[W-1:0];
    endfunction

    always @(negedge ck) begin
        ciclo++;
        if (rst) begin
            LED = 1'b0;
            cnt = 0;
        end else begin
            if (inicio) begin
                n_inicio++;
                ciclo_ini = ciclo;
                q_x.push_back(X);
                q_abc.push_back({A, B, C});
                op_x = X; op_a = A; op_b = B; op_c = C;
                cnt = m_never ? 0 : m_atraso;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    LED = 1'b1;
                    Resultado = poli(op_a, op_b, op_c, op_x);
                end
            end
            if (pronto) begin
                n_pronto++;
                LED = 1'b0;
            end
            if (res_valido) begin
                q_dado.push_back(res_dado);
                q_idx.push_back(res_indice);
            end
            if (fim) begin
                n_fim++;
                ciclo_fim = ciclo;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            erros++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic passo();
        @(posedge ck);
        #1;
    endtask

    task automatic zeros(input string tag);
        chk(tag, {inicio, pronto, X, A, B, C, res_dado, res_indice,
                  res_valido, ocupado, fim, erro_timeout}, 128'(0));
    endtask

    task automatic dispara(input logic [W-1:0] xv, av, bv, cv,
                           input logic [WC-1:0] nv);
        x0 = xv; a_in = av; b_in = bv; c_in = cv; n_jobs = nv;
        cmd_inicio = 1'b1;
        passo();
        cmd_inicio = 1'b0;
    endtask

    task automatic varre(input string tag, input logic [W-1:0] xv, av, bv, cv,
                         input int n, input int atraso, input bit ruido);
        int bf, bi, bp, br, nr, ni;
        bit ok;
        logic [W-1:0] xk;
        bf = n_fim; bi = n_inicio; bp = n_pronto; br = q_dado.size();
        m_atraso = atraso;
        m_never = 1'b0;
        dispara(xv, av, bv, cv, WC'(n));
        chk({tag, " ocupado"}, ocupado, 1);
        ok = 1'b0;
        for (int i = 0; i < n * (atraso + 10) + 20 && !ok; i++) begin
            if (ruido && i == 3) begin
                cmd_inicio = 1'b1;
                x0 = W'($urandom);
                a_in = W'($urandom);
                n_jobs = WC'($urandom);
            end else if (ruido && i == 4) begin
                cmd_inicio = 1'b0;
            end
            passo();
            if (n_fim > bf) ok = 1'b1;
        end
        cmd_inicio = 1'b0;
        chk({tag, " fim seen"}, ok, 1);
        nr = q_dado.size() - br;
        ni = n_inicio - bi;
        chk({tag, " n_res"}, nr, n);
        chk({tag, " n_inicio"}, ni, n);
        chk({tag, " n_pronto"}, n_pronto - bp, n);
        chk({tag, " n_fim"}, n_fim - bf, 1);
        for (int k = 0; k < nr && k < n; k++) begin
            xk = xv + W'(k);
            chk($sformatf("%s idx%0d", tag, k), q_idx[br + k], k);
            chk($sformatf("%s dado%0d", tag, k), q_dado[br + k],
                poli(av, bv, cv, xk));
        end
        for (int k = 0; k < ni && k < n; k++) begin
            xk = xv + W'(k);
            chk($sformatf("%s X%0d", tag, k), q_x[bi + k], xk);
            chk($sformatf("%s abc%0d", tag, k), q_abc[bi + k], {av, bv, cv});
        end
        chk({tag, " ocupado end"}, ocupado, 0);
        chk({tag, " erro end"}, erro_timeout, 0);
    endtask

    initial begin
        int b0, bi, bf, bp, br;
        bit ok;

        rst = 1'b1;
        passo();
        passo();
        zeros("reset");
        rst = 1'b0;
        passo();
        zeros("idle");

        // 1: single job
        b0 = q_dado.size();
        varre("t1", 16'd23, 16'd38, 16'd333, 16'd4902, 1, 3, 1'b0);
        chk("t1 const", q_dado[b0], 16'h7F97);

        // 2: two jobs, X steps
        b0 = q_dado.size();
        bi = n_inicio;
        varre("t2", 16'd23, 16'd38, 16'd333, 16'd4902, 2, 3, 1'b0);
        chk("t2 const0", q_dado[b0], 16'h7F97);
        chk("t2 const1", q_dado[b0 + 1], 16'h87DE);
        chk("t2 X1", q_x[bi + 1], 16'd24);

        // 3: X wraps
        bi = n_inicio;
        varre("t3", 16'hFFFF, 16'd38, 16'd333, 16'd4902, 2, 3, 1'b0);
        chk("t3 X wrap", q_x[bi + 1], 16'h0000);

        // 4: zero jobs
        bi = n_inicio; bf = n_fim; br = q_dado.size();
        dispara(16'd5, 16'd1, 16'd2, 16'd3, 8'd0);
        chk("t4 ocupado", ocupado, 1);
        chk("t4 fim early", fim, 0);
        passo();
        chk("t4 fim", fim, 1);
        chk("t4 ocupado off", ocupado, 0);
        passo();
        chk("t4 fim one", fim, 0);
        chk("t4 inicio", n_inicio - bi, 0);
        chk("t4 res", q_dado.size() - br, 0);
        chk("t4 nfim", n_fim - bf, 1);

        // 5: timeout
        m_never = 1'b1;
        bf = n_fim; bp = n_pronto; br = q_dado.size();
        dispara(16'd7, 16'd1, 16'd1, 16'd1, 8'd1);
        ok = 1'b0;
        for (int i = 0; i < 4 * TO && !ok; i++) begin
            passo();
            if (n_fim > bf) ok = 1'b1;
        end
        chk("t5 fim seen", ok, 1);
        chk("t5 erro", erro_timeout, 1);
        chk("t5 latency", ciclo_fim - ciclo_ini, TO + 1);
        chk("t5 pronto", n_pronto - bp, 0);
        chk("t5 res", q_dado.size() - br, 0);
        m_never = 1'b0;
        dispara(16'd7, 16'd1, 16'd1, 16'd1, 8'd1);
        chk("t5 erro clr", erro_timeout, 0);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            passo();
            if (n_fim > bf + 1) ok = 1'b1;
        end
        chk("t5 rerun fim", ok, 1);
        chk("t5 rerun dado", q_dado[q_dado.size() - 1],
            poli(16'd1, 16'd1, 16'd1, 16'd7));

        // 6: reset mid-sweep, foreign cmd ignored
        m_atraso = 3;
        bi = n_inicio; bp = n_pronto; br = q_dado.size();
        dispara(16'd100, 16'd3, 16'd4, 16'd5, 8'd4);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            passo();
            if (n_inicio > bi) ok = 1'b1;
        end
        chk("t6 inicio seen", ok, 1);
        cmd_inicio = 1'b1;
        x0 = 16'd900;
        chk("t6 ocupado", ocupado, 1);
        passo();
        cmd_inicio = 1'b0;
        chk("t6 X kept", X, 16'd100);
        @(negedge ck);
        #2;
        rst = 1'b1;
        #1;
        zeros("t6 async rst");
        passo();
        passo();
        rst = 1'b0;
        passo();
        passo();
        zeros("t6 after rst");
        chk("t6 pronto", n_pronto - bp, 0);
        chk("t6 res", q_dado.size() - br, 0);
        chk("t6 inicio", n_inicio - bi, 1);

        // randomized sweeps with foreign cmd pulses
        for (int r = 0; r < 4; r++) begin
            varre($sformatf("rnd%0d", r), W'($urandom), W'($urandom),
                  W'($urandom), W'($urandom), int'($urandom_range(1, 6)),
                  int'($urandom_range(1, 6)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, erros);
        $finish;
    end

endmodule
